// File: rtl/count_down_timer.sv
// Loadable down-counter/timer with pause, done pulse and optional auto-reload.
// Counts to zero without wrapping; serves as an interval/timeout source.
module count_down_timer #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } state_e;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] preset_q, preset_d;
  logic             done_q, done_d;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    preset_d = preset_q;
    done_d   = 1'b0;
    if (load) begin
      cnt_d    = load_value;
      preset_d = load_value;
      state_d  = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            if (cnt_q != '0) begin
              state_d = RUN;
            end else begin
              state_d = DONE;
              done_d  = 1'b1;
            end
          end
        end
        RUN: begin
          priority case (1'b1)
            pause: begin
              state_d = PAUSED;
            end
            (cnt_q > ONE): begin
              cnt_d = cnt_q - ONE;
            end
            (cnt_q == ONE): begin
              done_d = 1'b1;
              if (AUTO_RELOAD) begin
                cnt_d = preset_q;
              end else begin
                cnt_d   = '0;
                state_d = DONE;
              end
            end
            // a zero count cannot be running; park safely
            default: begin
              state_d = DONE;
            end
          endcase
        end
        PAUSED: begin
          if (!pause) begin
            state_d = RUN;
          end
        end
        DONE: begin
          if (start) begin
            if (preset_q != '0) begin
              cnt_d   = preset_q;
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      preset_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      preset_q <= preset_d;
      done_q   <= done_d;
    end
  end

  assign out  = cnt_q;
  assign busy = (state_q == RUN) || (state_q == PAUSED);
  assign done = done_q;

endmodule

// File: tb/tb_count_down_timer.sv
// Bench for count_down_timer: one-shot and auto-reload instances side by side,
// directed scenarios plus random stimulus against a behavioural model.
module tb_count_down_timer;

  logic       clk = 1'b0;
  logic       reset;
  logic       load;
  logic [3:0] load_value;
  logic       start;
  logic       pause;
  logic [3:0] out0, out1;
  logic       busy0, busy1;
  logic       done0, done1;

  int checks = 0;
  int errors = 0;

  localparam int PH_IDLE = 0;
  localparam int PH_RUN  = 1;
  localparam int PH_HOLD = 2;
  localparam int PH_FIN  = 3;

  int m_out[2];
  int m_pre[2];
  int m_ph[2];
  bit m_done[2];

  always #5 clk = ~clk;

  count_down_timer #(.WIDTH(4), .AUTO_RELOAD(1'b0)) dut0 (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .out(out0), .busy(busy0), .done(done0)
  );

  count_down_timer #(.WIDTH(4), .AUTO_RELOAD(1'b1)) dut1 (
    .clk(clk), .reset(reset), .load(load), .load_value(load_value),
    .start(start), .pause(pause), .out(out1), .busy(busy1), .done(done1)
  );

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_out[i] = 0; m_pre[i] = 0; m_ph[i] = PH_IDLE; m_done[i] = 1'b0;
    end
  endtask

  // Index i doubles as the auto-reload setting of that instance.
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (load) begin
        m_out[i] = int'(load_value);
        m_pre[i] = int'(load_value);
        m_ph[i]  = PH_IDLE;
      end else if (m_ph[i] == PH_IDLE) begin
        if (start) begin
          if (m_out[i] != 0) m_ph[i] = PH_RUN;
          else begin m_ph[i] = PH_FIN; m_done[i] = 1'b1; end
        end
      end else if (m_ph[i] == PH_RUN) begin
        if (pause) m_ph[i] = PH_HOLD;
        else if (m_out[i] > 1) m_out[i] = m_out[i] - 1;
        else begin
          m_done[i] = 1'b1;
          if (i == 1) m_out[i] = m_pre[i];
          else begin m_out[i] = 0; m_ph[i] = PH_FIN; end
        end
      end else if (m_ph[i] == PH_HOLD) begin
        if (!pause) m_ph[i] = PH_RUN;
      end else begin
        if (start) begin
          if (m_pre[i] != 0) begin m_out[i] = m_pre[i]; m_ph[i] = PH_RUN; end
          else m_done[i] = 1'b1;
        end
      end
    end
  endtask

  task automatic cyc(input bit l, input int lv, input bit s, input bit p);
    load = l;
    load_value = lv[3:0];
    start = s;
    pause = p;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if (out0 !== 4'd0 || out1 !== 4'd0) begin
      errors++;
      $display("FAIL reset_out: got %0d/%0d want 0", out0, out1);
    end
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy: got %b/%b want 0", busy0, busy1);
    end
    checks++;
    if (done0 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_done: got %b/%b want 0", done0, done1);
    end
    #5 reset = 1'b1;
  endtask

  task automatic test_async_reset();
    cyc(1'b1, 9, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    checks++;
    if (out0 !== 4'd9 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre: got out=%0d busy=%b want 9/1", out0, busy0);
    end
    load = 1'b0; start = 1'b0; pause = 1'b0;
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (out0 !== 4'd0 || out1 !== 4'd0) begin
      errors++;
      $display("FAIL arst_out: got %0d/%0d want 0", out0, out1);
    end
    checks++;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL arst_busy: got %b/%b want 0", busy0, busy1);
    end
    #1 reset = 1'b1;
  endtask

  task automatic test_count();
    int exp_q[$] = '{4, 3, 2, 1, 0};
    cyc(1'b1, 5, 1'b0, 1'b0);
    checks++;
    if (out0 !== 4'd5 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL cnt_load: got out=%0d busy=%b want 5/0", out0, busy0);
    end
    cyc(1'b0, 0, 1'b1, 1'b0);
    checks++;
    if (out0 !== 4'd5 || busy0 !== 1'b1 || done0 !== 1'b0) begin
      errors++;
      $display("FAIL cnt_start: got out=%0d busy=%b done=%b want 5/1/0",
               out0, busy0, done0);
    end
    foreach (exp_q[k]) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      checks++;
      if (out0 !== exp_q[k][3:0] || done0 !== (exp_q[k] == 0)) begin
        errors++;
        $display("FAIL cnt_seq: got out=%0d done=%b want %0d", out0, done0,
                 exp_q[k]);
      end
      checks++;
      if (out1 !== m_out[1][3:0] || done1 !== m_done[1]) begin
        errors++;
        $display("FAIL cnt_ar: got out=%0d done=%b want %0d/%b", out1, done1,
                 m_out[1], m_done[1]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      checks++;
      if (out0 !== 4'd0 || busy0 !== 1'b0 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL cnt_after: got out=%0d busy=%b done=%b want 0/0/0",
                 out0, busy0, done0);
      end
    end
  endtask

  task automatic test_pause();
    int exp_q[$] = '{2, 1, 0};
    cyc(1'b1, 6, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) cyc(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (out0 !== 4'd3) begin
      errors++;
      $display("FAIL pause_pre: got %0d want 3", out0);
    end
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 0, 1'b0, 1'b1);
      checks++;
      if (out0 !== 4'd3 || busy0 !== 1'b1 || out1 !== 4'd3) begin
        errors++;
        $display("FAIL pause_hold: got out=%0d/%0d busy=%b want 3/3/1",
                 out0, out1, busy0);
      end
    end
    cyc(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (out0 !== 4'd3 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL pause_rel: got out=%0d busy=%b want 3/1", out0, busy0);
    end
    foreach (exp_q[k]) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      checks++;
      if (out0 !== exp_q[k][3:0] || done0 !== (exp_q[k] == 0)) begin
        errors++;
        $display("FAIL pause_seq: got out=%0d done=%b want %0d", out0, done0,
                 exp_q[k]);
      end
    end
  endtask

  task automatic test_autoreload();
    cyc(1'b1, 3, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    checks++;
    if (out1 !== 4'd3 || busy1 !== 1'b1) begin
      errors++;
      $display("FAIL ar_start: got out=%0d busy=%b want 3/1", out1, busy1);
    end
    for (int k = 1; k <= 9; k++) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      checks++;
      if (out1 !== 4'(3 - (k % 3)) || done1 !== (k % 3 == 0) ||
          busy1 !== 1'b1) begin
        errors++;
        $display("FAIL ar_seq: got out=%0d done=%b busy=%b want %0d/%b/1",
                 out1, done1, busy1, 3 - (k % 3), (k % 3 == 0));
      end
      checks++;
      if (out0 !== m_out[0][3:0] || done0 !== m_done[0]) begin
        errors++;
        $display("FAIL ar_oneshot: got out=%0d done=%b want %0d/%b", out0,
                 done0, m_out[0], m_done[0]);
      end
    end
    cyc(1'b1, 1, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      checks++;
      if (out1 !== 4'd1 || done1 !== 1'b1) begin
        errors++;
        $display("FAIL ar_one: got out=%0d done=%b want 1/1", out1, done1);
      end
    end
  endtask

  task automatic test_load_start();
    cyc(1'b1, 7, 1'b1, 1'b0);
    checks++;
    if (out0 !== 4'd7 || busy0 !== 1'b0 || out1 !== 4'd7 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL ls_same: got out=%0d/%0d busy=%b/%b want 7/7/0/0",
               out0, out1, busy0, busy1);
    end
    cyc(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (out0 !== 4'd7 || busy0 !== 1'b0) begin
      errors++;
      $display("FAIL ls_idle: got out=%0d busy=%b want 7/0", out0, busy0);
    end
    cyc(1'b1, 0, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    checks++;
    if (done0 !== 1'b1 || out0 !== 4'd0 || busy0 !== 1'b0 || done1 !== 1'b1) begin
      errors++;
      $display("FAIL ls_zero: got done=%b/%b out=%0d busy=%b want 1/1/0/0",
               done0, done1, out0, busy0);
    end
    cyc(1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (done0 !== 1'b0 || done1 !== 1'b0) begin
      errors++;
      $display("FAIL ls_pulse: got %b/%b want 0", done0, done1);
    end
  endtask

  task automatic test_no_wrap();
    cyc(1'b1, 15, 1'b0, 1'b0);
    cyc(1'b0, 0, 1'b1, 1'b0);
    for (int k = 1; k <= 15; k++) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      checks++;
      if (out0 !== 4'(15 - k) || done0 !== (k == 15)) begin
        errors++;
        $display("FAIL wrap_seq: got out=%0d done=%b want %0d", out0, done0,
                 15 - k);
      end
    end
    for (int k = 0; k < 5; k++) begin
      cyc(1'b0, 0, 1'b0, 1'b0);
      checks++;
      if (out0 !== 4'd0 || done0 !== 1'b0) begin
        errors++;
        $display("FAIL wrap_hold: got out=%0d done=%b want 0/0", out0, done0);
      end
    end
    cyc(1'b0, 0, 1'b1, 1'b0);
    checks++;
    if (out0 !== 4'd15 || busy0 !== 1'b1) begin
      errors++;
      $display("FAIL wrap_restart: got out=%0d busy=%b want 15/1", out0, busy0);
    end
  endtask

  task automatic test_random();
    cyc(1'b1, 0, 1'b0, 1'b0);
    for (int k = 0; k < 600; k++) begin
      cyc(($urandom_range(0, 11) == 0), int'($urandom_range(0, 5)),
          ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
      checks++;
      if (out0 !== m_out[0][3:0] || done0 !== m_done[0] ||
          busy0 !== (m_ph[0] == PH_RUN || m_ph[0] == PH_HOLD)) begin
        errors++;
        $display("FAIL rnd0 @%0d: got out=%0d done=%b busy=%b want %0d/%b/%0d",
                 k, out0, done0, busy0, m_out[0], m_done[0], m_ph[0]);
      end
      checks++;
      if (out1 !== m_out[1][3:0] || done1 !== m_done[1] ||
          busy1 !== (m_ph[1] == PH_RUN || m_ph[1] == PH_HOLD)) begin
        errors++;
        $display("FAIL rnd1 @%0d: got out=%0d done=%b busy=%b want %0d/%b/%0d",
                 k, out1, done1, busy1, m_out[1], m_done[1], m_ph[1]);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    load = 1'b0;
    load_value = 4'd0;
    start = 1'b0;
    pause = 1'b0;
    model_reset();
    test_reset();
    test_async_reset();
    test_count();
    test_pause();
    test_autoreload();
    test_load_start();
    test_no_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
